hdlc_packet_deframer: RTL and testbench

Parametrised byte-stream deframer for the NoC ingress path. It accepts a flag-delimited, byte-stuffed serial byte stream (flag 0x7E, escape 0x7D, escaped byte XOR 0x20). It extracts a destination byte plus a fixed-length payload and queues completed packets in an output FIFO with valid/ready handshake. Malformed frames are dropped and reported, and the block adds input flow control that the first-generation receiver lacked.

---
 rtl/hdlc_packet_deframer_pkg.sv | 31 +++
 rtl/hdlc_packet_deframer_if.sv | 24 ++
 rtl/hdlc_packet_deframer_pkt_fifo.sv | 73 +++++++
 rtl/hdlc_packet_deframer.sv | 217 +++++++++++++++++++++
 tb/tb_hdlc_packet_deframer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdlc_packet_deframer_pkg.sv
// Shared constants, state type and CRC helper for the HDLC packet deframer.
// Optional CRC-8 check is enabled by defining HDLC_DEFRAMER_CRC_EN.
package hdlc_packet_deframer_pkg;

   localparam logic [7:0] HDLC_FLAG = 8'h7E;
   localparam logic [7:0] HDLC_ESC  = 8'h7D;
   localparam logic [7:0] HDLC_XOR  = 8'h20;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_DEST,
      ST_PAYLOAD,
`ifdef HDLC_DEFRAMER_CRC_EN
      ST_CRC,
`endif
      ST_TAIL
   } dfr_state_e;

`ifdef HDLC_DEFRAMER_CRC_EN
   // CRC-8, poly 0x07, MSB first: fold one byte into the running remainder.
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
      logic [7:0] c;
      c = crc ^ din;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction
`endif

endpackage

// File: rtl/hdlc_packet_deframer_if.sv
// Byte-stream input and packet output handshake bundle of the deframer.
interface hdlc_packet_deframer_if #(
   parameter int unsigned PAYLOAD_BYTES = 4
);
   localparam int unsigned DATA_W = 8 * PAYLOAD_BYTES;

   logic [7:0]        in_byte;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        out_dest;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  in_byte, in_valid, out_ready,
      output in_ready, out_dest, out_data, out_valid
   );

   modport master (
      output in_byte, in_valid, out_ready,
      input  in_ready, out_dest, out_data, out_valid
   );
endinterface

// File: rtl/hdlc_packet_deframer_pkt_fifo.sv
// Parametrised-width first-word-fall-through FIFO with registered full/empty
// flags; full_nxt_c exposes the flag value that the next edge will load.
module pkt_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             full_nxt_c
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             push_ok, pop_ok;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      push_ok = push && !full_q;
      pop_ok  = pop && !empty_q;
      if (push_ok) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_d = rd_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      full_d  = (cnt_d == CW'(DEPTH));
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   assign dout       = mem_q[rd_q];
   assign full       = full_q;
   assign empty      = empty_q;
   assign full_nxt_c = full_d;

endmodule

// File: rtl/hdlc_packet_deframer.sv
// Flag-delimited, byte-stuffed stream deframer feeding a packet FIFO.
// Define HDLC_DEFRAMER_CRC_EN to expect and check a trailing CRC-8 byte.
module hdlc_packet_deframer
   import hdlc_packet_deframer_pkg::*;
#(
   parameter int unsigned PAYLOAD_BYTES = 4,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   hdlc_packet_deframer_if.slave       bus,
   output logic                        err_len,
   output logic                        err_esc,
   output logic                        err_crc,
   output logic [15:0]                 drop_count
);
   localparam int unsigned DATA_W = 8 * PAYLOAD_BYTES;
   localparam int unsigned PKT_W  = DATA_W + 8;
   localparam int unsigned CNT_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES - 1);

   dfr_state_e        state_q, state_d;
   logic              esc_q, esc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        dest_q, dest_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_len_q, err_len_d;
   logic              err_esc_q, err_esc_d;
   logic [15:0]       drop_q, drop_d;
   logic              in_ready_q, in_ready_d;
`ifdef HDLC_DEFRAMER_CRC_EN
   logic [7:0]        crc_q, crc_d;
   logic              crc_bad_q, crc_bad_d;
   logic              err_crc_q, err_crc_d;
`endif

   logic              accept_c, is_flag_c, is_esc_c, push_c, drop_c;
   logic [7:0]        dbyte_c;
   logic [PKT_W-1:0]  fifo_dout;
   logic              fifo_full, fifo_empty, fifo_full_nxt_c;

   // Frame parser: destuffing, field extraction and error classification.
   always_comb begin
      state_d    = state_q;
      esc_d      = esc_q;
      cnt_d      = cnt_q;
      dest_d     = dest_q;
      data_d     = data_q;
      err_len_d  = 1'b0;
      err_esc_d  = 1'b0;
      drop_d     = drop_q;
      push_c     = 1'b0;
      drop_c     = 1'b0;
      in_ready_d = !fifo_full_nxt_c;
      accept_c   = bus.in_valid && in_ready_q && !fifo_full;
      is_flag_c  = (bus.in_byte == HDLC_FLAG);
      is_esc_c   = (bus.in_byte == HDLC_ESC);
      dbyte_c    = esc_q ? (bus.in_byte ^ HDLC_XOR) : bus.in_byte;
`ifdef HDLC_DEFRAMER_CRC_EN
      crc_d      = crc_q;
      crc_bad_d  = crc_bad_q;
      err_crc_d  = 1'b0;
`endif

      if (accept_c) begin
         if (state_q == ST_HUNT) begin
            esc_d = 1'b0;
            if (is_flag_c) state_d = ST_DEST;
         end else if (is_flag_c) begin
            esc_d   = 1'b0;
            state_d = ST_DEST;
            if (esc_q) begin
               err_esc_d = 1'b1;
               drop_c    = 1'b1;
            end else begin
               case (state_q)
                  ST_PAYLOAD: begin
                     err_len_d = 1'b1;
                     drop_c    = 1'b1;
                  end
`ifdef HDLC_DEFRAMER_CRC_EN
                  ST_CRC: begin
                     err_len_d = 1'b1;
                     drop_c    = 1'b1;
                  end
                  ST_TAIL: begin
                     if (crc_bad_q) begin
                        err_crc_d = 1'b1;
                        drop_c    = 1'b1;
                     end else begin
                        push_c = 1'b1;
                     end
                  end
`else
                  ST_TAIL: push_c = 1'b1;
`endif
                  default: ;
               endcase
            end
         end else if (is_esc_c && !esc_q) begin
            esc_d = 1'b1;
         end else if (is_esc_c) begin
            esc_d     = 1'b0;
            err_esc_d = 1'b1;
            drop_c    = 1'b1;
            state_d   = ST_HUNT;
         end else begin
            esc_d = 1'b0;
            case (state_q)
               ST_DEST: begin
                  dest_d  = dbyte_c;
                  cnt_d   = '0;
                  state_d = ST_PAYLOAD;
`ifdef HDLC_DEFRAMER_CRC_EN
                  crc_d   = crc8_next(8'h00, dbyte_c);
`endif
               end
               ST_PAYLOAD: begin
                  data_d = DATA_W'({data_q, dbyte_c});
`ifdef HDLC_DEFRAMER_CRC_EN
                  crc_d  = crc8_next(crc_q, dbyte_c);
`endif
                  if (cnt_q == LAST_CNT) begin
                     cnt_d = '0;
`ifdef HDLC_DEFRAMER_CRC_EN
                     state_d = ST_CRC;
`else
                     state_d = ST_TAIL;
`endif
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
`ifdef HDLC_DEFRAMER_CRC_EN
               ST_CRC: begin
                  crc_bad_d = (dbyte_c != crc_q);
                  state_d   = ST_TAIL;
               end
`endif
               ST_TAIL: begin
                  err_len_d = 1'b1;
                  drop_c    = 1'b1;
                  state_d   = ST_HUNT;
               end
               default: ;
            endcase
         end
      end

      if (drop_c && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_HUNT;
         esc_q      <= 1'b0;
         cnt_q      <= '0;
         dest_q     <= '0;
         data_q     <= '0;
         err_len_q  <= 1'b0;
         err_esc_q  <= 1'b0;
         drop_q     <= '0;
         in_ready_q <= 1'b0;
`ifdef HDLC_DEFRAMER_CRC_EN
         crc_q      <= '0;
         crc_bad_q  <= 1'b0;
         err_crc_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         esc_q      <= esc_d;
         cnt_q      <= cnt_d;
         dest_q     <= dest_d;
         data_q     <= data_d;
         err_len_q  <= err_len_d;
         err_esc_q  <= err_esc_d;
         drop_q     <= drop_d;
         in_ready_q <= in_ready_d;
`ifdef HDLC_DEFRAMER_CRC_EN
         crc_q      <= crc_d;
         crc_bad_q  <= crc_bad_d;
         err_crc_q  <= err_crc_d;
`endif
      end
   end

   pkt_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_c),
      .din        ({dest_q, data_q}),
      .pop        (bus.out_ready && !fifo_empty),
      .dout       (fifo_dout),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .full_nxt_c (fifo_full_nxt_c)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_dest  = fifo_dout[PKT_W-1 -: 8];
   assign bus.out_data  = fifo_dout[DATA_W-1:0];
   assign err_len       = err_len_q;
   assign err_esc       = err_esc_q;
   assign drop_count    = drop_q;
`ifdef HDLC_DEFRAMER_CRC_EN
   assign err_crc       = err_crc_q;
`else
   assign err_crc       = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_packet_deframer.sv
// Directed, table-driven bench for hdlc_packet_deframer (PAYLOAD_BYTES=4, FIFO_DEPTH=4).
module tb_hdlc_packet_deframer;
   localparam int unsigned PB = 4;
   localparam int unsigned FD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        err_len, err_esc, err_crc;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   hdlc_packet_deframer_if #(.PAYLOAD_BYTES(PB)) bus ();

   hdlc_packet_deframer #(.PAYLOAD_BYTES(PB), .FIFO_DEPTH(FD)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .err_len    (err_len),
      .err_esc    (err_esc),
      .err_crc    (err_crc),
      .drop_count (drop_count)
   );

   int passed = 0;
   int total  = 0;
   int n_len  = 0;
   int n_esc  = 0;
   int n_crc  = 0;
   logic [7:0]  q_dest [$];
   logic [31:0] q_data [$];

   // Counts error pulse cycles and records every popped packet.
   always @(negedge clk) begin
      if (err_len) n_len++;
      if (err_esc) n_esc++;
      if (err_crc) n_crc++;
      if (bus.out_valid && bus.out_ready) begin
         q_dest.push_back(bus.out_dest);
         q_data.push_back(bus.out_data);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Called and returns at posedge+1; waits (bounded) for in_ready.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_byte  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) begin
         total++;
         $display("FAIL in_ready_timeout: got 0 expected 1 (byte %0h)", b);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_stuffed(input logic [7:0] b);
      if (b == 8'h7E || b == 8'h7D) begin
         send_byte(8'h7D);
         send_byte(b ^ 8'h20);
      end else begin
         send_byte(b);
      end
   endtask

`ifdef HDLC_DEFRAMER_CRC_EN
   function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      logic       fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[7] ^ d[i];
         r  = {r[6:0], 1'b0};
         if (fb) r = r ^ 8'h07;
      end
      return r;
   endfunction

   task automatic send_frame(input logic [7:0] dest, input logic [31:0] data);
      logic [7:0] c;
      logic [7:0] b;
      c = crc_ref(8'h00, dest);
      send_byte(8'h7E);
      send_stuffed(dest);
      for (int k = 0; k < PB; k++) begin
         b = data[8*(PB-1-k) +: 8];
         send_stuffed(b);
         c = crc_ref(c, b);
      end
      send_stuffed(c);
      send_byte(8'h7E);
   endtask
`else
   task automatic send_frame(input logic [7:0] dest, input logic [31:0] data);
      send_byte(8'h7E);
      send_stuffed(dest);
      for (int k = 0; k < PB; k++) send_stuffed(data[8*(PB-1-k) +: 8]);
      send_byte(8'h7E);
   endtask
`endif

   typedef struct {
      logic [95:0] seq;
      int          len;
      bit          pkt;
      logic [7:0]  dest;
      logic [31:0] data;
      int          nlen;
      int          nesc;
      int          drops;
   } vec_t;

   vec_t vecs [8];
   int   l0, e0, c0, p0, n;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{96'h7E11223344557E,         7, 1'b1, 8'h11, 32'h22334455, 0, 0, 0};
      vecs[1] = '{96'h7E7D5E7D5D44557D5D7E,  10, 1'b1, 8'h7E, 32'h7D44557D, 0, 0, 0};
      vecs[2] = '{96'h7E01027E,               4, 1'b0, 8'h00, 32'h0,        1, 0, 1};
      vecs[3] = '{96'h7E0102030405067E,       8, 1'b0, 8'h00, 32'h0,        1, 0, 2};
      vecs[4] = '{96'h7E017D7E01020304057E,  10, 1'b1, 8'h01, 32'h02030405, 0, 1, 3};
      vecs[5] = '{96'h7E7D7D7EAA010203047E,  10, 1'b1, 8'hAA, 32'h01020304, 0, 1, 4};
      vecs[6] = '{96'h7E7E7E3300FF7D5E107E,  10, 1'b1, 8'h33, 32'h00FF7E10, 0, 0, 4};
      vecs[7] = '{96'h7E427D312233447E,       8, 1'b1, 8'h42, 32'h11223344, 0, 0, 4};

      bus.in_byte   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state while rst is held high.
      #12;
      check("rst_in_ready",  64'(bus.in_ready), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_dest",  64'(bus.out_dest), 64'(0));
      check("rst_out_data",  64'(bus.out_data), 64'(0));
      check("rst_err_len",   64'(err_len), 64'(0));
      check("rst_err_esc",   64'(err_esc), 64'(0));
      check("rst_err_crc",   64'(err_crc), 64'(0));
      check("rst_drops",     64'(drop_count), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

`ifndef HDLC_DEFRAMER_CRC_EN
      for (int i = 0; i < 8; i++) begin
         l0 = n_len;
         e0 = n_esc;
         p0 = q_dest.size();
         for (int k = 0; k < vecs[i].len; k++) send_byte(vecs[i].seq[8*(vecs[i].len-1-k) +: 8]);
         check($sformatf("v%0d_valid_latency", i), 64'(bus.out_valid), 64'(vecs[i].pkt));
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("v%0d_err_len", i), 64'(n_len - l0), 64'(vecs[i].nlen));
         check($sformatf("v%0d_err_esc", i), 64'(n_esc - e0), 64'(vecs[i].nesc));
         check($sformatf("v%0d_drops", i), 64'(drop_count), 64'(vecs[i].drops));
         check($sformatf("v%0d_pkts", i), 64'(q_dest.size() - p0), 64'(vecs[i].pkt));
         if (vecs[i].pkt && q_dest.size() > p0) begin
            check($sformatf("v%0d_dest", i), 64'(q_dest[p0]), 64'(vecs[i].dest));
            check($sformatf("v%0d_data", i), 64'(q_data[p0]), 64'(vecs[i].data));
         end
      end
      check("crc_tied_off", 64'(n_crc), 64'(0));
`else
      // Good CRC accepted, then same frame with a corrupted CRC byte dropped.
      p0 = q_dest.size();
      send_frame(8'h11, 32'h22334455);
      check("crc_good_valid", 64'(bus.out_valid), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      check("crc_good_pkts", 64'(q_dest.size() - p0), 64'(1));
      check("crc_good_data", 64'(q_data[p0]), 64'(32'h22334455));
      check("crc_good_drops", 64'(drop_count), 64'(0));
      c0 = n_crc;
      p0 = q_dest.size();
      send_byte(8'h7E);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      send_stuffed(crc_ref(crc_ref(crc_ref(crc_ref(crc_ref(8'h00, 8'h11), 8'h22), 8'h33), 8'h44), 8'h55) ^ 8'h01);
      send_byte(8'h7E);
      repeat (3) @(posedge clk);
      #1;
      check("crc_bad_err", 64'(n_crc - c0), 64'(1));
      check("crc_bad_drops", 64'(drop_count), 64'(1));
      check("crc_bad_pkts", 64'(q_dest.size() - p0), 64'(0));
`endif

      // Reset in mid-frame discards the partial frame without a drop.
      send_byte(8'h7E);
      send_byte(8'h55);
      send_byte(8'h01);
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
      check("midrst_drops", 64'(drop_count), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      l0 = n_len;
      e0 = n_esc;
      p0 = q_dest.size();
      send_frame(8'h66, 32'hCAFEF00D);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_pkts", 64'(q_dest.size() - p0), 64'(1));
      check("midrst_dest", 64'(q_dest[p0]), 64'(8'h66));
      check("midrst_data", 64'(q_data[p0]), 64'(32'hCAFEF00D));
      check("midrst_errs", 64'((n_len - l0) + (n_esc - e0)), 64'(0));

      // Backpressure: four frames fill the FIFO, the fifth waits for pops.
      bus.out_ready = 1'b0;
      q_dest.delete();
      q_data.delete();
      for (int i = 0; i < 4; i++) begin
         send_frame(8'hA0 + 8'(i), 32'h10203040 + 32'(i));
         if (i == 2) check("bp_ready_not_full", 64'(bus.in_ready), 64'(1));
      end
      check("bp_ready_full", 64'(bus.in_ready), 64'(0));
      check("bp_head_dest", 64'(bus.out_dest), 64'(8'hA0));
      fork
         send_frame(8'hA4, 32'h10203044);
         begin
            repeat (4) @(posedge clk);
            #1;
            check("bp_ready_held", 64'(bus.in_ready), 64'(0));
            bus.out_ready = 1'b1;
         end
      join
      n = 0;
      while (q_dest.size() < 5 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_count", 64'(q_dest.size()), 64'(5));
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp%0d_dest", i), 64'(q_dest[i]), 64'(8'hA0 + 8'(i)));
         check($sformatf("bp%0d_data", i), 64'(q_data[i]), 64'(32'h10203040 + 32'(i)));
      end
      check("bp_drops", 64'(drop_count), 64'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
